// File: rtl/retire_ctrl_pkg.sv
// rtl/retire_ctrl_pkg.sv - shared widths, ROB entry packet and retirement state enum
package retire_ctrl_pkg;

   localparam int PR   = 6;
   localparam int XLEN = 32;
   localparam int ROB  = 32;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      RECOVER = 2'd1,
      HALTED  = 2'd2
   } RETIRE_STATE;

   typedef struct packed {
      logic            valid;
      logic            completed;
      logic            halt;
      logic            precise_state_need;
      logic [4:0]      arch_reg;
      logic [PR-1:0]   Told;
      logic [PR-1:0]   Tnew;
      logic [XLEN-1:0] target_pc;
   } ROB_ENTRY_PACKET;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
   endfunction

endpackage

// File: rtl/retire_select.sv
// rtl/retire_select.sv - in-order commit prefix with halt/recovery boundary detection
module retire_select (
   input  logic       enable_i,
   input  logic [2:0] valid_i,
   input  logic [2:0] completed_i,
   input  logic [2:0] halt_i,
   input  logic [2:0] psn_i,
   output logic [2:0] retire_mask_o,
   output logic [2:0] recover_way_o,
   output logic [2:0] halt_way_o
);

   logic open;

   // Walk oldest (way 2) to youngest; 'open' closes on a stall or a boundary.
   always_comb begin
      retire_mask_o = '0;
      recover_way_o = '0;
      halt_way_o    = '0;
      open          = enable_i;
      for (int i = 2; i >= 0; i--) begin
         if (open && valid_i[i] && completed_i[i]) begin
            retire_mask_o[i] = 1'b1;
            if (halt_i[i]) begin
               halt_way_o[i] = 1'b1;
               open          = 1'b0;
            end else if (psn_i[i]) begin
               recover_way_o[i] = 1'b1;
               open             = 1'b0;
            end
         end else begin
            open = 1'b0;
         end
      end
   end

endmodule

// File: rtl/retire_ctrl.sv
// rtl/retire_ctrl.sv - retirement controller: commit select, recovery/halt FSM, map/free outputs
// Optional statistics counters are enabled by defining RETIRE_STATS_EN.
module retire_ctrl
   import retire_ctrl_pkg::*;
#(
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  ROB_ENTRY_PACKET [2:0]     rob_head_entry,
   input  logic                      retire_hold,
   output logic [2:0]                retire_mask,
   output logic [2:0]                free_valid,
   output logic [2:0][PR-1:0]        free_preg,
   output logic [2:0]                map_we,
   output logic [2:0][4:0]           map_arch,
   output logic [2:0][PR-1:0]        map_preg,
   output logic                      BPRecoverEN,
   output logic [XLEN-1:0]           recover_pc,
`ifdef RETIRE_STATS_EN
   output logic [31:0]               retired_count,
   output logic [15:0]               recover_count,
`endif
   output logic                      halted
);

   RETIRE_STATE     state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            bp_q, bp_d;
   logic [XLEN-1:0] pc_q, pc_d;

   logic [2:0]      valid_v, completed_v, halt_v, psn_v;
   logic [2:0]      recover_way, halt_way;
   logic [XLEN-1:0] sel_pc;
   logic            sel_enable;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         valid_v[i]     = rob_head_entry[i].valid;
         completed_v[i] = rob_head_entry[i].completed;
         halt_v[i]      = rob_head_entry[i].halt;
         psn_v[i]       = rob_head_entry[i].precise_state_need;
      end
   end

   assign sel_enable = (state_q == RUN) && !retire_hold && !reset;

   retire_select u_select (
      .enable_i      (sel_enable),
      .valid_i       (valid_v),
      .completed_i   (completed_v),
      .halt_i        (halt_v),
      .psn_i         (psn_v),
      .retire_mask_o (retire_mask),
      .recover_way_o (recover_way),
      .halt_way_o    (halt_way)
   );

   always_comb begin
      free_valid = '0;
      free_preg  = '0;
      map_we     = '0;
      map_arch   = '0;
      map_preg   = '0;
      sel_pc     = '0;
      for (int i = 0; i < 3; i++) begin
         if (retire_mask[i] && rob_head_entry[i].arch_reg != 5'd0) begin
            free_valid[i] = 1'b1;
            free_preg[i]  = rob_head_entry[i].Told;
            map_we[i]     = 1'b1;
            map_arch[i]   = rob_head_entry[i].arch_reg;
            map_preg[i]   = rob_head_entry[i].Tnew;
         end
         if (recover_way[i]) begin
            sel_pc = rob_head_entry[i].target_pc;
         end
      end
   end

   // recover_way is only ever set in RUN, so halt_way taking priority here is
   // equivalent to "halt wins" on a single entry carrying both flags.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bp_d    = 1'b0;
      pc_d    = pc_q;
      case (state_q)
         RUN: begin
            if (|halt_way) begin
               state_d = HALTED;
            end else if (|recover_way) begin
               state_d = RECOVER;
               cnt_d   = 4'(RECOVER_CYCLES);
               bp_d    = 1'b1;
               pc_d    = sel_pc;
            end
         end
         RECOVER: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         bp_q    <= 1'b0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bp_q    <= bp_d;
         pc_q    <= pc_d;
      end
   end

   assign BPRecoverEN = bp_q;
   assign recover_pc  = pc_q;
   assign halted      = (state_q == HALTED);

`ifdef RETIRE_STATS_EN
   logic [31:0] retired_count_q;
   logic [15:0] recover_count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         retired_count_q <= '0;
         recover_count_q <= '0;
      end else begin
         retired_count_q <= retired_count_q + 32'(popcount3(retire_mask));
         recover_count_q <= recover_count_q + 16'(bp_q);
      end
   end

   assign retired_count = retired_count_q;
   assign recover_count = recover_count_q;
`endif

endmodule

// File: tb/tb_retire_ctrl.sv
// tb/tb_retire_ctrl.sv - directed self-checking bench for retire_ctrl
module tb_retire_ctrl;
   import retire_ctrl_pkg::*;

   logic                 clock;
   logic                 reset;
   ROB_ENTRY_PACKET [2:0] rob_head_entry;
   logic                 retire_hold;
   logic [2:0]           retire_mask;
   logic [2:0]           free_valid;
   logic [2:0][PR-1:0]   free_preg;
   logic [2:0]           map_we;
   logic [2:0][4:0]      map_arch;
   logic [2:0][PR-1:0]   map_preg;
   logic                 BPRecoverEN;
   logic [XLEN-1:0]      recover_pc;
   logic                 halted;
`ifdef RETIRE_STATS_EN
   logic [31:0]          retired_count;
   logic [15:0]          recover_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   retire_ctrl #(.RECOVER_CYCLES(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .rob_head_entry (rob_head_entry),
      .retire_hold    (retire_hold),
      .retire_mask    (retire_mask),
      .free_valid     (free_valid),
      .free_preg      (free_preg),
      .map_we         (map_we),
      .map_arch       (map_arch),
      .map_preg       (map_preg),
      .BPRecoverEN    (BPRecoverEN),
      .recover_pc     (recover_pc),
`ifdef RETIRE_STATS_EN
      .retired_count  (retired_count),
      .recover_count  (recover_count),
`endif
      .halted         (halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic ROB_ENTRY_PACKET mk(input logic v, input logic c, input logic h, input logic p,
                                          input logic [4:0] a, input logic [PR-1:0] to,
                                          input logic [PR-1:0] tn, input logic [XLEN-1:0] pc);
      ROB_ENTRY_PACKET e;
      e.valid = v; e.completed = c; e.halt = h; e.precise_state_need = p;
      e.arch_reg = a; e.Told = to; e.Tnew = tn; e.target_pc = pc;
      return e;
   endfunction

   task automatic set_full();
      rob_head_entry[2] = mk(1, 1, 0, 0, 5'd1, 6'd1, 6'd32, 32'd0);
      rob_head_entry[1] = mk(1, 1, 0, 0, 5'd2, 6'd2, 6'd33, 32'd0);
      rob_head_entry[0] = mk(1, 1, 0, 0, 5'd3, 6'd3, 6'd34, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_full();
      @(negedge clock);
      #2;
      n_cmp++; if (retire_mask !== 3'b000) begin n_fail++; $display("FAIL reset_mask got %b want 000", retire_mask); end
      n_cmp++; if (free_valid !== 3'b000 || map_we !== 3'b000) begin n_fail++; $display("FAIL reset_side got %b/%b want 000/000", free_valid, map_we); end
      n_cmp++; if (BPRecoverEN !== 1'b0 || recover_pc !== 32'd0) begin n_fail++; $display("FAIL reset_bp got %b/%0d want 0/0", BPRecoverEN, recover_pc); end
      n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_full_commit();
      set_full();
      #2;
      n_cmp++; if (retire_mask !== 3'b111) begin n_fail++; $display("FAIL full_mask got %b want 111", retire_mask); end
      n_cmp++; if (free_valid !== 3'b111 || map_we !== 3'b111) begin n_fail++; $display("FAIL full_we got %b/%b want 111/111", free_valid, map_we); end
      n_cmp++; if (free_preg[2] !== 6'd1 || free_preg[1] !== 6'd2 || free_preg[0] !== 6'd3) begin n_fail++; $display("FAIL full_free got %0d,%0d,%0d want 1,2,3", free_preg[2], free_preg[1], free_preg[0]); end
      n_cmp++; if (map_arch[2] !== 5'd1 || map_arch[1] !== 5'd2 || map_arch[0] !== 5'd3) begin n_fail++; $display("FAIL full_arch got %0d,%0d,%0d want 1,2,3", map_arch[2], map_arch[1], map_arch[0]); end
      n_cmp++; if (map_preg[2] !== 6'd32 || map_preg[1] !== 6'd33 || map_preg[0] !== 6'd34) begin n_fail++; $display("FAIL full_tnew got %0d,%0d,%0d want 32,33,34", map_preg[2], map_preg[1], map_preg[0]); end
      @(negedge clock);
   endtask

   task automatic test_head_not_completed();
      set_full();
      rob_head_entry[2].completed = 1'b0;
      #2;
      n_cmp++; if (retire_mask !== 3'b000) begin n_fail++; $display("FAIL headwait_mask got %b want 000", retire_mask); end
      n_cmp++; if (free_valid !== 3'b000 || map_we !== 3'b000) begin n_fail++; $display("FAIL headwait_side got %b/%b want 000/000", free_valid, map_we); end
      @(negedge clock);
      rob_head_entry[2].completed = 1'b1;
      #2;
      n_cmp++; if (retire_mask !== 3'b111) begin n_fail++; $display("FAIL headdone_mask got %b want 111", retire_mask); end
      @(negedge clock);
   endtask

   task automatic test_invalid();
      rob_head_entry = '0;
      #2;
      n_cmp++; if (retire_mask !== 3'b000) begin n_fail++; $display("FAIL invalid_mask got %b want 000", retire_mask); end
      @(negedge clock);
   endtask

   task automatic test_recover();
      set_full();
      rob_head_entry[1] = mk(1, 1, 0, 1, 5'd2, 6'd2, 6'd33, 32'd32);
      #2;
      n_cmp++; if (retire_mask !== 3'b110) begin n_fail++; $display("FAIL rec_T_mask got %b want 110", retire_mask); end
      n_cmp++; if (free_valid !== 3'b110) begin n_fail++; $display("FAIL rec_T_free got %b want 110", free_valid); end
      n_cmp++; if (BPRecoverEN !== 1'b0) begin n_fail++; $display("FAIL rec_T_bp got %b want 0", BPRecoverEN); end
      @(negedge clock);
      set_full();
      #2;
      n_cmp++; if (BPRecoverEN !== 1'b1 || recover_pc !== 32'd32) begin n_fail++; $display("FAIL rec_T1_bp got %b/%0d want 1/32", BPRecoverEN, recover_pc); end
      n_cmp++; if (retire_mask !== 3'b000) begin n_fail++; $display("FAIL rec_T1_mask got %b want 000", retire_mask); end
      @(negedge clock);
      #2;
      n_cmp++; if (BPRecoverEN !== 1'b0 || retire_mask !== 3'b000) begin n_fail++; $display("FAIL rec_T2 got bp %b mask %b want 0/000", BPRecoverEN, retire_mask); end
      @(negedge clock);
      #2;
      n_cmp++; if (retire_mask !== 3'b111 || BPRecoverEN !== 1'b0) begin n_fail++; $display("FAIL rec_T3 got mask %b bp %b want 111/0", retire_mask, BPRecoverEN); end
      @(negedge clock);
   endtask

   task automatic test_halt();
      set_full();
      rob_head_entry[2].halt = 1'b1;
      #2;
      n_cmp++; if (retire_mask !== 3'b100 || free_valid !== 3'b100) begin n_fail++; $display("FAIL halt_T got mask %b free %b want 100/100", retire_mask, free_valid); end
      n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_T_flag got %b want 0", halted); end
      @(negedge clock);
      set_full();
      for (int k = 0; k < 5; k++) begin
         #2;
         n_cmp++; if (halted !== 1'b1 || retire_mask !== 3'b000) begin n_fail++; $display("FAIL halt_hold%0d got halted %b mask %b want 1/000", k, halted, retire_mask); end
         @(negedge clock);
      end
      do_reset();
   endtask

   task automatic test_halt_wins();
      set_full();
      rob_head_entry[2] = mk(1, 1, 1, 1, 5'd1, 6'd1, 6'd32, 32'd99);
      #2;
      n_cmp++; if (retire_mask !== 3'b100) begin n_fail++; $display("FAIL hwin_mask got %b want 100", retire_mask); end
      @(negedge clock);
      set_full();
      #2;
      n_cmp++; if (BPRecoverEN !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL hwin_T1 got bp %b halted %b want 0/1", BPRecoverEN, halted); end
      @(negedge clock);
      do_reset();
   endtask

   task automatic test_arch_zero_and_hold();
      set_full();
      rob_head_entry[0].arch_reg = 5'd0;
      #2;
      n_cmp++; if (retire_mask !== 3'b111) begin n_fail++; $display("FAIL az_mask got %b want 111", retire_mask); end
      n_cmp++; if (free_valid !== 3'b110 || map_we !== 3'b110) begin n_fail++; $display("FAIL az_side got %b/%b want 110/110", free_valid, map_we); end
      n_cmp++; if (free_preg[0] !== 6'd0 || map_preg[0] !== 6'd0) begin n_fail++; $display("FAIL az_zero got %0d/%0d want 0/0", free_preg[0], map_preg[0]); end
      retire_hold = 1'b1;
      #1;
      n_cmp++; if (retire_mask !== 3'b000 || free_valid !== 3'b000) begin n_fail++; $display("FAIL hold got mask %b free %b want 000/000", retire_mask, free_valid); end
      retire_hold = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_in_recover();
      set_full();
      rob_head_entry[2] = mk(1, 1, 0, 1, 5'd1, 6'd1, 6'd32, 32'd64);
      #2;
      n_cmp++; if (retire_mask !== 3'b100) begin n_fail++; $display("FAIL rir_T_mask got %b want 100", retire_mask); end
      @(negedge clock);
      set_full();
      reset = 1'b1;
      #2;
      n_cmp++; if (retire_mask !== 3'b000 || map_we !== 3'b000) begin n_fail++; $display("FAIL rir_gate got mask %b we %b want 000/000", retire_mask, map_we); end
      @(negedge clock);
      reset = 1'b0;
      #2;
      n_cmp++; if (BPRecoverEN !== 1'b0 || recover_pc !== 32'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL rir_regs got bp %b pc %0d halted %b want 0/0/0", BPRecoverEN, recover_pc, halted); end
      n_cmp++; if (retire_mask !== 3'b111) begin n_fail++; $display("FAIL rir_resume got %b want 111", retire_mask); end
      @(negedge clock);
   endtask

   initial begin
      reset       = 1'b1;
      retire_hold = 1'b0;
      rob_head_entry = '0;
      test_reset();
      test_full_commit();
      test_head_not_completed();
      test_invalid();
      test_recover();
      test_halt();
      test_halt_wins();
      test_arch_zero_and_hold();
      test_reset_in_recover();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
